// File: rtl/millis_timer_scheduler.sv
// Multi-channel compare/alarm scheduler for the free-running millisecond timer.
// Optional STATUS overrun flag compiled in with `define MILLIS_SCHED_OVERRUN_EN.
module millis_timer_scheduler #(
    parameter int TIMER_WIDTH  = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TIMER_WIDTH-1:0] timer_value,
    input  logic                   we,
    input  logic                   re,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [TIMER_WIDTH-1:0] wdata,
    output logic [TIMER_WIDTH-1:0] rdata,
    output logic                   irq
);

    localparam int CH_W = ADDR_WIDTH - 2;

    localparam logic [1:0] REG_CMP    = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } ch_state_t;

    ch_state_t              r_state    [NUM_CHANNELS];
    ch_state_t              w_state_n  [NUM_CHANNELS];
    logic [TIMER_WIDTH-1:0] r_cmp      [NUM_CHANNELS];
    logic [TIMER_WIDTH-1:0] w_cmp_n    [NUM_CHANNELS];
    logic [TIMER_WIDTH-1:0] r_period   [NUM_CHANNELS];
    logic [TIMER_WIDTH-1:0] w_period_n [NUM_CHANNELS];
    logic [TIMER_WIDTH-1:0] w_diff     [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] r_periodic;
    logic [NUM_CHANNELS-1:0] w_periodic_n;
    logic [NUM_CHANNELS-1:0] r_irq_en;
    logic [NUM_CHANNELS-1:0] w_irq_en_n;
    logic [NUM_CHANNELS-1:0] r_pend;
    logic [NUM_CHANNELS-1:0] w_pend_n;
    logic [NUM_CHANNELS-1:0] w_ovr;
    logic [NUM_CHANNELS-1:0] w_sel;
    logic [NUM_CHANNELS-1:0] w_cfg_wr;
    logic [NUM_CHANNELS-1:0] w_expired;
    logic [NUM_CHANNELS-1:0] w_fire;

    logic [CH_W-1:0]        w_ch;
    logic [1:0]             w_reg;
    logic [TIMER_WIDTH-1:0] w_rd;

    assign w_ch  = addr[ADDR_WIDTH-1:2];
    assign w_reg = addr[1:0];

    // Channel indices beyond NUM_CHANNELS never match, so such writes fall away.
    always_comb begin
        w_sel     = '0;
        w_cfg_wr  = '0;
        w_expired = '0;
        w_fire    = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            w_diff[c]    = timer_value - r_cmp[c];
            w_sel[c]     = we && (w_ch == CH_W'(c));
            w_cfg_wr[c]  = w_sel[c] && (w_reg != REG_STATUS);
            w_expired[c] = (r_state[c] == ST_ARMED) && !w_diff[c][TIMER_WIDTH-1];
            w_fire[c]    = w_expired[c] && !w_cfg_wr[c];
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_cmp_n      = r_cmp;
        w_period_n   = r_period;
        w_periodic_n = r_periodic;
        w_irq_en_n   = r_irq_en;
        w_pend_n     = r_pend;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            case (r_state[c])
                ST_ARMED: begin
                    if (w_fire[c]) begin
                        if (r_periodic[c] && (r_period[c] != '0)) begin
                            w_cmp_n[c] = r_cmp[c] + r_period[c];
                        end else begin
                            w_state_n[c] = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
            if (w_sel[c]) begin
                case (w_reg)
                    REG_CMP:    w_cmp_n[c]    = wdata;
                    REG_PERIOD: w_period_n[c] = wdata;
                    REG_CTRL: begin
                        w_state_n[c]    = wdata[0] ? ST_ARMED : ST_IDLE;
                        w_periodic_n[c] = wdata[1];
                        w_irq_en_n[c]   = wdata[2];
                    end
                    default: ;
                endcase
            end
            // A fresh firing beats a simultaneous write-1-to-clear.
            w_pend_n[c] = w_fire[c] |
                          (r_pend[c] & ~(w_sel[c] & (w_reg == REG_STATUS) & wdata[0]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c]  <= ST_IDLE;
                r_cmp[c]    <= '0;
                r_period[c] <= '0;
            end
            r_periodic <= '0;
            r_irq_en   <= '0;
            r_pend     <= '0;
        end else begin
            r_state    <= w_state_n;
            r_cmp      <= w_cmp_n;
            r_period   <= w_period_n;
            r_periodic <= w_periodic_n;
            r_irq_en   <= w_irq_en_n;
            r_pend     <= w_pend_n;
        end
    end

`ifdef MILLIS_SCHED_OVERRUN_EN
    logic [NUM_CHANNELS-1:0] r_ovr;
    logic [NUM_CHANNELS-1:0] w_ovr_n;

    always_comb begin
        w_ovr_n = r_ovr;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            w_ovr_n[c] = (w_fire[c] & r_pend[c]) |
                         (r_ovr[c] & ~(w_sel[c] & (w_reg == REG_STATUS) & wdata[1]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr <= '0;
        end else begin
            r_ovr <= w_ovr_n;
        end
    end

    assign w_ovr = r_ovr;
`else
    assign w_ovr = '0;
`endif

    always_comb begin
        w_rd = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (w_ch == CH_W'(c)) begin
                case (w_reg)
                    REG_CMP:    w_rd      = r_cmp[c];
                    REG_PERIOD: w_rd      = r_period[c];
                    REG_CTRL:   w_rd[2:0] = {r_irq_en[c], r_periodic[c], r_state[c] == ST_ARMED};
                    default:    w_rd[1:0] = {w_ovr[c], r_pend[c]};
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= w_rd;
        end
    end

    assign irq = |(r_pend & r_irq_en);

endmodule

// File: tb/tb_millis_timer_scheduler.sv
// Directed bench for millis_timer_scheduler with a per-channel behavioural model.
module tb_millis_timer_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] timer_value = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

`ifdef MILLIS_SCHED_OVERRUN_EN
    localparam logic [31:0] OVR_STATUS = 32'd3;
`else
    localparam logic [31:0] OVR_STATUS = 32'd1;
`endif

    millis_timer_scheduler #(
        .TIMER_WIDTH (32),
        .NUM_CHANNELS(4),
        .ADDR_WIDTH  (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .timer_value(timer_value),
        .we         (we),
        .re         (re),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Model state: one entry per channel, plus the registered read port.
    logic [31:0] m_cmp    [4];
    logic [31:0] m_period [4];
    bit          m_en     [4];
    bit          m_per    [4];
    bit          m_ie     [4];
    bit          m_pend   [4];
    bit          m_ovr    [4];
    logic [31:0] m_rdata;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        int ch = int'(a) / 4;
        int r  = int'(a) % 4;
        if (ch >= 4) return 32'd0;
        case (r)
            0: return m_cmp[ch];
            1: return m_period[ch];
            2: return {29'd0, m_ie[ch], m_per[ch], m_en[ch]};
`ifdef MILLIS_SCHED_OVERRUN_EN
            default: return {30'd0, m_ovr[ch], m_pend[ch]};
`else
            default: return {31'd0, m_pend[ch]};
`endif
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                m_cmp[c] = '0; m_period[c] = '0; m_en[c] = 0; m_per[c] = 0;
                m_ie[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
            end
            m_rdata = '0;
        end else begin
            if (re) m_rdata = model_read(addr);
            for (int c = 0; c < 4; c++) begin
                bit hit, cfg, due, fire;
                int r;
                hit  = we && (int'(addr) / 4 == c);
                r    = int'(addr) % 4;
                cfg  = hit && (r != 3);
                due  = m_en[c] && ($signed(timer_value - m_cmp[c]) >= 0);
                fire = due && !cfg;
                m_ovr[c]  = (fire && m_pend[c]) || (m_ovr[c] && !(hit && r == 3 && wdata[1]));
                m_pend[c] = fire || (m_pend[c] && !(hit && r == 3 && wdata[0]));
                if (fire) begin
                    if (m_per[c] && m_period[c] != 0) m_cmp[c] = m_cmp[c] + m_period[c];
                    else m_en[c] = 0;
                end
                if (cfg) begin
                    if (r == 0) m_cmp[c] = wdata;
                    if (r == 1) m_period[c] = wdata;
                    if (r == 2) begin
                        m_en[c] = wdata[0]; m_per[c] = wdata[1]; m_ie[c] = wdata[2];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            bit mi;
            mi = 0;
            for (int c = 0; c < 4; c++) mi |= m_pend[c] & m_ie[c];
            chk("model_irq", {31'd0, irq}, {31'd0, mi});
            chk("model_rdata", rdata, m_rdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        re = 1'b1; addr = a;
        cyc();
        re = 1'b0;
        chk(name, rdata, exp);
    endtask

    task automatic set_t(input logic [31:0] t);
        timer_value = t;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        cyc();
        started = 1'b1;
        cyc();
        reset = 1'b0;
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rd_chk("reset_status0", 5'd3, 32'd0);

        // One-shot on channel 0
        set_t(32'd95);
        wr(5'd0, 32'd100);
        wr(5'd2, 32'd5);
        for (int t = 96; t <= 105; t++) begin
            set_t(32'(t));
            if (t == 99)  chk("oneshot_irq_before", {31'd0, irq}, 32'd0);
            if (t == 100) chk("oneshot_irq_at", {31'd0, irq}, 32'd1);
        end
        rd_chk("oneshot_ctrl", 5'd2, 32'd4);
        set_t(32'd200);
        rd_chk("oneshot_status", 5'd3, 32'd1);
        wr(5'd3, 32'd1);
        chk("oneshot_clr_irq", {31'd0, irq}, 32'd0);

        // Periodic on channel 1
        set_t(32'd0);
        wr(5'd4, 32'd10);
        wr(5'd5, 32'd5);
        wr(5'd6, 32'd7);
        for (int t = 1; t <= 20; t++) set_t(32'(t));
        rd_chk("periodic_cmp", 5'd4, 32'd25);
        rd_chk("periodic_status", 5'd7, OVR_STATUS);
        wr(5'd7, 32'd3);
        chk("periodic_clr_irq", {31'd0, irq}, 32'd0);
        wr(5'd6, 32'd0);

        // Wrap-around on channel 2
        set_t(32'hFFFF_FFF0);
        wr(5'd8, 32'd5);
        wr(5'd10, 32'd5);
        for (int i = 0; i <= 21; i++) begin
            set_t(32'hFFFF_FFF0 + 32'(i));
            if (i == 15) chk("wrap_irq_ffff", {31'd0, irq}, 32'd0);
            if (i == 20) chk("wrap_irq_4", {31'd0, irq}, 32'd0);
            if (i == 21) chk("wrap_irq_5", {31'd0, irq}, 32'd1);
        end
        wr(5'd11, 32'd1);

        // Collisions on channel 3
        set_t(32'd40);
        wr(5'd12, 32'd50);
        wr(5'd14, 32'd5);
        set_t(32'd49);
        timer_value = 32'd50;
        wr(5'd12, 32'd500);
        chk("collide_irq", {31'd0, irq}, 32'd0);
        rd_chk("collide_status", 5'd15, 32'd0);
        set_t(32'd499);
        chk("collide_irq_499", {31'd0, irq}, 32'd0);
        set_t(32'd500);
        chk("collide_irq_500", {31'd0, irq}, 32'd1);
        wr(5'd12, 32'd510);
        wr(5'd14, 32'd5);
        set_t(32'd509);
        timer_value = 32'd510;
        wr(5'd15, 32'd1);
        chk("w1c_vs_fire_irq", {31'd0, irq}, 32'd1);
        rd_chk("w1c_vs_fire_status", 5'd15, OVR_STATUS);
        wr(5'd15, 32'd3);

        // Out-of-range addresses
        rd_chk("cmp3", 5'd12, 32'd510);
        rd_chk("oor_read16", 5'd16, 32'd0);
        wr(5'd16, 32'd123);
        rd_chk("oor_no_alias", 5'd0, 32'd100);
        rd_chk("oor_read31", 5'd31, 32'd0);

        // Periodic with PERIOD=0 behaves as one-shot
        set_t(32'd1000);
        wr(5'd1, 32'd0);
        wr(5'd0, 32'd1005);
        wr(5'd2, 32'd7);
        for (int t = 1001; t <= 1005; t++) set_t(32'(t));
        rd_chk("period0_ctrl", 5'd2, 32'd6);
        set_t(32'd1010);
        rd_chk("period0_status", 5'd3, 32'd1);
        wr(5'd3, 32'd3);

        // Overrun with PERIOD=1, pending never cleared
        set_t(32'd2000);
        wr(5'd5, 32'd1);
        wr(5'd4, 32'd2001);
        wr(5'd6, 32'd7);
        set_t(32'd2001);
        set_t(32'd2002);
        rd_chk("overrun_status", 5'd7, OVR_STATUS);

        // Reset while armed
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midreset_irq", {31'd0, irq}, 32'd0);
        chk("midreset_rdata", rdata, 32'd0);
        rd_chk("midreset_cmp1", 5'd4, 32'd0);
        rd_chk("midreset_period1", 5'd5, 32'd0);
        rd_chk("midreset_ctrl1", 5'd6, 32'd0);
        rd_chk("midreset_status1", 5'd7, 32'd0);

        cyc();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
